// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_pkg: 640x480@60 timing constants and the shared pixel type.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

   localparam int c_hActive = 640;
   localparam int c_hFp     = 16;
   localparam int c_hSync   = 96;
   localparam int c_hBp     = 48;
   localparam int c_vActive = 480;
   localparam int c_vFp     = 10;
   localparam int c_vSync   = 2;
   localparam int c_vBp     = 33;

   localparam int c_hTotal = c_hActive + c_hFp + c_hSync + c_hBp;
   localparam int c_vTotal = c_vActive + c_vFp + c_vSync + c_vBp;

   localparam int c_hSyncStart = c_hActive + c_hFp;
   localparam int c_hSyncEnd   = c_hSyncStart + c_hSync;
   localparam int c_vSyncStart = c_vActive + c_vFp;
   localparam int c_vSyncEnd   = c_vSyncStart + c_vSync;

   localparam int c_cntWidth = 10;
   localparam int c_rgbWidth = 24;

   typedef logic [c_rgbWidth-1:0] rgb_t;

   function automatic rgb_t packRgb(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
      return {r, g, b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen: scan counters, raw syncs, active flag and frame pulse.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = c_hActive,
   parameter int H_FP     = c_hFp,
   parameter int H_SYNC   = c_hSync,
   parameter int H_BP     = c_hBp,
   parameter int V_ACTIVE = c_vActive,
   parameter int V_FP     = c_vFp,
   parameter int V_SYNC   = c_vSync,
   parameter int V_BP     = c_vBp
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [c_cntWidth-1:0] o_xPos,
   output logic [c_cntWidth-1:0] o_yPos,
   output logic                  o_scanValid,
   output logic                  o_hsRaw,
   output logic                  o_vsRaw,
   output logic                  o_frameStart
);

   localparam logic [c_cntWidth-1:0] c_hLast    = c_cntWidth'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [c_cntWidth-1:0] c_vLast    = c_cntWidth'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [c_cntWidth-1:0] c_hAct     = c_cntWidth'(H_ACTIVE);
   localparam logic [c_cntWidth-1:0] c_vAct     = c_cntWidth'(V_ACTIVE);
   localparam logic [c_cntWidth-1:0] c_hsStart  = c_cntWidth'(H_ACTIVE + H_FP);
   localparam logic [c_cntWidth-1:0] c_hsEnd    = c_cntWidth'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_cntWidth-1:0] c_vsStart  = c_cntWidth'(V_ACTIVE + V_FP);
   localparam logic [c_cntWidth-1:0] c_vsEnd    = c_cntWidth'(V_ACTIVE + V_FP + V_SYNC);

   logic [c_cntWidth-1:0] r_hCnt;
   logic [c_cntWidth-1:0] r_vCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (r_hCnt == c_hLast) begin
         r_hCnt <= '0;
         r_vCnt <= (r_vCnt == c_vLast) ? '0 : r_vCnt + 1'b1;
      end else begin
         r_hCnt <= r_hCnt + 1'b1;
      end
   end

   assign o_xPos = r_hCnt;
   assign o_yPos = r_vCnt;

   // Gated by rst so layers and the alignment pipe see an idle scan while held.
   assign o_scanValid  = !rst && (r_hCnt < c_hAct) && (r_vCnt < c_vAct);
   assign o_hsRaw      = !((r_hCnt >= c_hsStart) && (r_hCnt < c_hsEnd));
   assign o_vsRaw      = !((r_vCnt >= c_vsStart) && (r_vCnt < c_vsEnd));
   assign o_frameStart = !rst && (r_hCnt == '0) && (r_vCnt == c_vAct);

endmodule
`default_nettype wire

// File: rtl/vga_scan_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_scan_mixer: drives scan position to layers, composites by priority.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vga_scan_mixer
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = c_hActive,
   parameter int   H_FP      = c_hFp,
   parameter int   H_SYNC    = c_hSync,
   parameter int   H_BP      = c_hBp,
   parameter int   V_ACTIVE  = c_vActive,
   parameter int   V_FP      = c_vFp,
   parameter int   V_SYNC    = c_vSync,
   parameter int   V_BP      = c_vBp,
   parameter int   LAYER_LAT = 1,
   parameter rgb_t BG_COLOR  = 24'h000000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [c_cntWidth-1:0] x_pos,
   output logic [c_cntWidth-1:0] y_pos,
   output logic                  scan_valid,
   input  logic                  RqFlag0,
   input  logic [7:0]            r0,
   input  logic [7:0]            g0,
   input  logic [7:0]            b0,
   input  logic                  RqFlag1,
   input  logic [7:0]            r1,
   input  logic [7:0]            g1,
   input  logic [7:0]            b1,
   output logic                  vga_hs,
   output logic                  vga_vs,
   output logic                  vga_de,
   output logic [7:0]            vga_r,
   output logic [7:0]            vga_g,
   output logic [7:0]            vga_b,
   output logic                  frame_start
);

   logic w_hsRaw, w_vsRaw, w_scanValid;
   logic w_hsD, w_vsD, w_deD;
   rgb_t w_pixel;

   logic r_vgaHs, r_vgaVs, r_vgaDe;
   rgb_t r_rgb;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .o_xPos       (x_pos),
      .o_yPos       (y_pos),
      .o_scanValid  (w_scanValid),
      .o_hsRaw      (w_hsRaw),
      .o_vsRaw      (w_vsRaw),
      .o_frameStart (frame_start)
   );

   assign scan_valid = w_scanValid;

   // Delay sync/active by the layer latency so they line up with RqFlag/RGB.
   if (LAYER_LAT == 0) begin : g_noAlign
      assign w_hsD = w_hsRaw;
      assign w_vsD = w_vsRaw;
      assign w_deD = w_scanValid;
   end else begin : g_align
      logic [LAYER_LAT-1:0] r_hsSr;
      logic [LAYER_LAT-1:0] r_vsSr;
      logic [LAYER_LAT-1:0] r_deSr;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_hsSr <= '1;
            r_vsSr <= '1;
            r_deSr <= '0;
         end else begin
            r_hsSr[0] <= w_hsRaw;
            r_vsSr[0] <= w_vsRaw;
            r_deSr[0] <= w_scanValid;
            for (int i = 1; i < LAYER_LAT; i++) begin
               r_hsSr[i] <= r_hsSr[i-1];
               r_vsSr[i] <= r_vsSr[i-1];
               r_deSr[i] <= r_deSr[i-1];
            end
         end
      end

      assign w_hsD = r_hsSr[LAYER_LAT-1];
      assign w_vsD = r_vsSr[LAYER_LAT-1];
      assign w_deD = r_deSr[LAYER_LAT-1];
   end

   // Layer 0 (sprite) sits above layer 1 (background); blanking is forced black.
   always_comb begin
      w_pixel = BG_COLOR;
      if (!w_deD) begin
         w_pixel = '0;
      end else if (RqFlag0) begin
         w_pixel = packRgb(r0, g0, b0);
      end else if (RqFlag1) begin
         w_pixel = packRgb(r1, g1, b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vgaHs <= 1'b1;
         r_vgaVs <= 1'b1;
         r_vgaDe <= 1'b0;
         r_rgb   <= '0;
      end else begin
         r_vgaHs <= w_hsD;
         r_vgaVs <= w_vsD;
         r_vgaDe <= w_deD;
         r_rgb   <= w_pixel;
      end
   end

   assign vga_hs = r_vgaHs;
   assign vga_vs = r_vgaVs;
   assign vga_de = r_vgaDe;
   assign vga_r  = r_rgb[23:16];
   assign vga_g  = r_rgb[15:8];
   assign vga_b  = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_scan_mixer: directed checks of timing, alignment and layer priority.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_vga_scan_mixer;

   // Vertical timing shortened so whole frames fit a short run; horizontal is 640x480 standard.
   localparam int c_vActive = 8;
   localparam int c_vFp     = 2;
   localparam int c_vSync   = 2;
   localparam int c_vBp     = 3;
   localparam int c_frame   = 800 * (c_vActive + c_vFp + c_vSync + c_vBp);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x_pos, y_pos;
   logic       scan_valid, frame_start;
   logic       RqFlag0 = 1'b0, RqFlag1 = 1'b0;
   logic [7:0] r0 = 8'hFF, g0 = 8'h00, b0 = 8'h00;
   logic [7:0] r1 = 8'h00, g1 = 8'h00, b1 = 8'hFF;
   logic       vga_hs, vga_vs, vga_de;
   logic [7:0] vga_r, vga_g, vga_b;

   int testCount = 0;
   int failCount = 0;

   vga_scan_mixer #(
      .V_ACTIVE  (c_vActive),
      .V_FP      (c_vFp),
      .V_SYNC    (c_vSync),
      .V_BP      (c_vBp),
      .LAYER_LAT (1),
      .BG_COLOR  (24'h123456)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .scan_valid  (scan_valid),
      .RqFlag0     (RqFlag0),
      .r0          (r0),
      .g0          (g0),
      .b0          (b0),
      .RqFlag1     (RqFlag1),
      .r1          (r1),
      .g1          (g1),
      .b1          (b1),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // One-clock layer: line 1 both flags everywhere, line 2 none, else sprite window over background.
   always @(posedge clk) begin
      case (y_pos)
         10'd1:   begin RqFlag0 <= 1'b1; RqFlag1 <= 1'b1; end
         10'd2:   begin RqFlag0 <= 1'b0; RqFlag1 <= 1'b0; end
         default: begin
            RqFlag0 <= (x_pos >= 10'd100) && (x_pos <= 10'd131);
            RqFlag1 <= 1'b1;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] expActive(input int line, input int px);
      if (line == 1) return 24'hFF0000;
      if (line == 2) return 24'h123456;
      return (px >= 100 && px <= 131) ? 24'hFF0000 : 24'h0000FF;
   endfunction

   // Entered at the sample where pixel 0 of the line reaches the outputs (x_pos == 2).
   task automatic runLine(input int line);
      int deCnt = 0, hsLow = 0, hsFirst = -1, vsLow = 0;
      int actErr = 0, blankErr = 0, redCnt = 0, redFirst = -1;
      logic [23:0] rgb;
      for (int j = 0; j < 800; j++) begin
         rgb = {vga_r, vga_g, vga_b};
         if (vga_de === 1'b1) deCnt++;
         if (vga_hs === 1'b0) begin
            hsLow++;
            if (hsFirst < 0) hsFirst = j;
         end
         if (vga_vs === 1'b0) vsLow++;
         if (j < 640) begin
            if (rgb !== expActive(line, j)) actErr++;
            if (rgb === 24'hFF0000) begin
               redCnt++;
               if (redFirst < 0) redFirst = j;
            end
         end else if (rgb !== 24'h0) begin
            blankErr++;
         end
         @(negedge clk);
      end
      check($sformatf("line%0d deCnt", line), deCnt, 640);
      check($sformatf("line%0d hsFirst", line), hsFirst, 656);
      check($sformatf("line%0d hsLow", line), hsLow, 96);
      check($sformatf("line%0d vsLow", line), vsLow, 0);
      check($sformatf("line%0d activeErr", line), actErr, 0);
      check($sformatf("line%0d blankErr", line), blankErr, 0);
      if (line == 0) begin
         check("line0 redCnt", redCnt, 32);
         check("line0 redFirst", redFirst, 100);
      end
   endtask

   initial begin
      int k1 = -1, k2 = -1, vsLowCnt = 0, vsFallY = -1, vsFallX = -1, n;
      bit found;

      // Reset held for five clocks.
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst x_pos", x_pos, 0);
      check("rst y_pos", y_pos, 0);
      check("rst vga_hs", vga_hs, 1);
      check("rst vga_vs", vga_vs, 1);
      check("rst vga_de", vga_de, 0);
      check("rst rgb", {vga_r, vga_g, vga_b}, 0);
      check("rst scan_valid", scan_valid, 0);
      check("rst frame_start", frame_start, 0);

      rst = 1'b0;
      #1;
      check("rel x_pos", x_pos, 0);
      check("rel scan_valid", scan_valid, 1);
      @(negedge clk);
      check("rel+1 vga_de", vga_de, 0);
      check("rel+1 x_pos", x_pos, 1);
      @(negedge clk);
      check("rel+2 vga_de", vga_de, 1);

      runLine(0);
      runLine(1);
      runLine(2);
      check("period x_pos", x_pos, 2);
      check("period y_pos", y_pos, 3);

      // Frame pulse spacing and vsync window across one full frame.
      for (int k = 0; k < 3 * c_frame; k++) begin
         if (frame_start === 1'b1) begin
            if (k1 < 0) begin
               k1 = k;
               check("fs y_pos", y_pos, c_vActive);
               check("fs x_pos", x_pos, 0);
            end else begin
               k2 = k;
               break;
            end
         end
         if (k1 >= 0 && vga_vs === 1'b0) begin
            if (vsFallY < 0) begin
               vsFallY = y_pos;
               vsFallX = x_pos;
            end
            vsLowCnt++;
         end
         @(negedge clk);
      end
      check("fs period", k2 - k1, c_frame);
      check("vs lowCnt", vsLowCnt, 1600);
      check("vs fall y", vsFallY, c_vActive + c_vFp);
      check("vs fall x", vsFallX, 2);

      // Mid-frame reset for one clock.
      found = 1'b0;
      for (int k = 0; k < 2 * c_frame; k++) begin
         if (y_pos == 10'd5 && x_pos == 10'd300) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("mid reset point reached", found, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid x_pos", x_pos, 0);
      check("mid y_pos", y_pos, 0);
      check("mid vga_de 0", vga_de, 0);
      check("mid vga_hs", vga_hs, 1);
      check("mid vga_vs", vga_vs, 1);
      @(negedge clk);
      check("mid vga_de 1", vga_de, 0);
      @(negedge clk);
      check("mid vga_de 2", vga_de, 1);
      n = -1;
      for (int k = 2; k < c_frame; k++) begin
         if (frame_start === 1'b1) begin
            n = k;
            break;
         end
         @(negedge clk);
      end
      check("mid fs delay", n, 800 * c_vActive);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
